// File: rtl/ddr3_ctrl_pkg.sv
// Shared types and constants for the DDR3 Avalon command arbiter.
package ddr3_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_CMD  = 2'd2,
        ST_READ_DATA = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 128;

    localparam logic [2:0] AVL_SIZE_IDLE = 3'd0;
    localparam logic [2:0] AVL_SIZE_WR   = 3'd1;

    // One-hot grant encoding shared by the picker and the arbiter FSM.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_WR   = 2'b01;
    localparam logic [1:0] GNT_RD   = 2'b10;

endpackage

// File: rtl/ddr3_rr_pick.sv
// Two-way round-robin picker: on a tie, grants the side that was not served last.
module ddr3_rr_pick
    import ddr3_ctrl_pkg::*;
(
    input  logic       i_wr_req,
    input  logic       i_rd_req,
    input  logic       i_last_rd,
    output logic [1:0] o_grant
);

    always_comb begin
        // NOTE: default first so every path assigns o_grant and no latch is inferred.
        o_grant = GNT_NONE;
        if (i_wr_req && i_rd_req) begin
            o_grant = i_last_rd ? GNT_WR : GNT_RD;
        end else if (i_wr_req) begin
            o_grant = GNT_WR;
        end else if (i_rd_req) begin
            o_grant = GNT_RD;
        end
    end

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Write/read arbiter in front of a DDR3 Avalon controller, one transaction at a time.
// Optional read-data watchdog enabled by defining DDR3_ARB_TIMEOUT_EN.
module ddr3_avl_arbiter
    import ddr3_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RD_BURST       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              ddr3_clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_done,
    output logic              rd_err,
    input  logic              ddr3_avl_ready,
    output logic              ddr3_avl_burstbegin,
    output logic              ddr3_avl_write_req,
    output logic              ddr3_avl_read_req,
    output logic [ADDR_W-1:0] ddr3_avl_addr,
    output logic [DATA_W-1:0] ddr3_avl_wr_data,
    output logic [2:0]        ddr3_avl_size,
    input  logic [DATA_W-1:0] ddr3_avl_rdata,
    input  logic              ddr3_avl_rdata_valid
);

    localparam logic [2:0] SIZE_RD   = 3'(RD_BURST);
    localparam logic [2:0] LAST_BEAT = 3'(RD_BURST - 1);

    arb_state_t        r_state;
    logic              r_last_rd;
    logic [2:0]        r_beat;
    logic              r_wr_done;
    logic              r_rd_done;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_burstbegin;
    logic              r_write_req;
    logic              r_read_req;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_size;
    logic [1:0]        w_grant;

`ifdef DDR3_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
    logic [WDOG_W-1:0] r_wdog;
    logic              r_rd_err;
    assign rd_err = r_rd_err;
`else
    assign rd_err = 1'b0;
`endif

    ddr3_rr_pick u_rr_pick (
        .i_wr_req  (wr_req),
        .i_rd_req  (rd_req),
        .i_last_rd (r_last_rd),
        .o_grant   (w_grant)
    );

    always_ff @(posedge ddr3_clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_rd    <= 1'b1;
            r_beat       <= '0;
            r_wr_done    <= 1'b0;
            r_rd_done    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_burstbegin <= 1'b0;
            r_write_req  <= 1'b0;
            r_read_req   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= AVL_SIZE_IDLE;
`ifdef DDR3_ARB_TIMEOUT_EN
            r_wdog       <= '0;
            r_rd_err     <= 1'b0;
`endif
        end else begin
            r_wr_done  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                // Requests are not granted while a done pulse is visible, so the
                // requester has a cycle to drop its request line.
                ST_IDLE: begin
                    if (!r_wr_done && !r_rd_done) begin
                        if (w_grant == GNT_WR) begin
                            r_state      <= ST_WRITE;
                            r_addr       <= wr_addr;
                            r_wdata      <= wr_data;
                            r_burstbegin <= 1'b1;
                            r_write_req  <= 1'b1;
                            r_size       <= AVL_SIZE_WR;
                            r_last_rd    <= 1'b0;
                        end else if (w_grant == GNT_RD) begin
                            r_state      <= ST_READ_CMD;
                            r_addr       <= rd_addr;
                            r_burstbegin <= 1'b1;
                            r_read_req   <= 1'b1;
                            r_size       <= SIZE_RD;
                            r_last_rd    <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (ddr3_avl_ready) begin
                        r_state      <= ST_IDLE;
                        r_burstbegin <= 1'b0;
                        r_write_req  <= 1'b0;
                        r_size       <= AVL_SIZE_IDLE;
                        r_wr_done    <= 1'b1;
                    end
                end
                ST_READ_CMD: begin
                    if (ddr3_avl_ready) begin
                        r_state      <= ST_READ_DATA;
                        r_burstbegin <= 1'b0;
                        r_read_req   <= 1'b0;
                        r_size       <= AVL_SIZE_IDLE;
                        r_beat       <= '0;
`ifdef DDR3_ARB_TIMEOUT_EN
                        r_wdog       <= '0;
`endif
                    end
                end
                ST_READ_DATA: begin
                    if (ddr3_avl_rdata_valid) begin
                        r_rd_data  <= ddr3_avl_rdata;
                        r_rd_valid <= 1'b1;
`ifdef DDR3_ARB_TIMEOUT_EN
                        r_wdog     <= '0;
`endif
                        if (r_beat == LAST_BEAT) begin
                            r_rd_done <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
`ifdef DDR3_ARB_TIMEOUT_EN
                    else if (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rd_done <= 1'b1;
                        r_rd_err  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_done             = r_wr_done;
    assign rd_done             = r_rd_done;
    assign rd_data_valid       = r_rd_valid;
    assign rd_data             = r_rd_data;
    assign ddr3_avl_burstbegin = r_burstbegin;
    assign ddr3_avl_write_req  = r_write_req;
    assign ddr3_avl_read_req   = r_read_req;
    assign ddr3_avl_addr       = r_addr;
    assign ddr3_avl_wr_data    = r_wdata;
    assign ddr3_avl_size       = r_size;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed self-checking bench for ddr3_avl_arbiter (watchdog scenario only with DDR3_ARB_TIMEOUT_EN).
module tb_ddr3_avl_arbiter;

    localparam int ADDR_W         = 26;
    localparam int DATA_W         = 128;
    localparam int RD_BURST       = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic              ddr3_clk = 1'b0;
    logic              reset_n;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_done;
    logic              rd_err;
    logic              ddr3_avl_ready;
    logic              ddr3_avl_burstbegin;
    logic              ddr3_avl_write_req;
    logic              ddr3_avl_read_req;
    logic [ADDR_W-1:0] ddr3_avl_addr;
    logic [DATA_W-1:0] ddr3_avl_wr_data;
    logic [2:0]        ddr3_avl_size;
    logic [DATA_W-1:0] ddr3_avl_rdata;
    logic              ddr3_avl_rdata_valid;

    logic [9:0] w_ctl;
    assign w_ctl = {wr_done, rd_data_valid, rd_done, rd_err, ddr3_avl_burstbegin,
                    ddr3_avl_write_req, ddr3_avl_read_req, ddr3_avl_size};

    int vectors     = 0;
    int miscompares = 0;

    ddr3_avl_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .RD_BURST       (RD_BURST),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .ddr3_clk             (ddr3_clk),
        .reset_n              (reset_n),
        .wr_req               (wr_req),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .wr_done              (wr_done),
        .rd_req               (rd_req),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .rd_data_valid        (rd_data_valid),
        .rd_done              (rd_done),
        .rd_err               (rd_err),
        .ddr3_avl_ready       (ddr3_avl_ready),
        .ddr3_avl_burstbegin  (ddr3_avl_burstbegin),
        .ddr3_avl_write_req   (ddr3_avl_write_req),
        .ddr3_avl_read_req    (ddr3_avl_read_req),
        .ddr3_avl_addr        (ddr3_avl_addr),
        .ddr3_avl_wr_data     (ddr3_avl_wr_data),
        .ddr3_avl_size        (ddr3_avl_size),
        .ddr3_avl_rdata       (ddr3_avl_rdata),
        .ddr3_avl_rdata_valid (ddr3_avl_rdata_valid)
    );

    always #5 ddr3_clk = ~ddr3_clk;

    // Outputs are sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge ddr3_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        ddr3_avl_ready = 1'b0; ddr3_avl_rdata = '0; ddr3_avl_rdata_valid = 1'b0;
        #3;
        vectors++;
        if (w_ctl !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b, expected %b", w_ctl, 10'd0);
        end
        vectors++;
        if ({ddr3_avl_addr, ddr3_avl_wr_data, rd_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, expected all zero",
                     ddr3_avl_addr, ddr3_avl_wr_data, rd_data);
        end
        repeat (2) step();
        reset_n = 1'b1;
        step();
        vectors++;
        if (w_ctl !== 10'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b, expected %b", w_ctl, 10'd0);
        end
    endtask

    task automatic test_write();
        int n_wr;
        int n_done;
        logic [DATA_W-1:0] exp_data;
        n_wr = 0;
        n_done = 0;
        exp_data = {96'h0, 32'hDEADBEEF};
        ddr3_avl_ready = 1'b0;
        wr_addr = 26'h0000100;
        wr_data = exp_data;
        wr_req  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ddr3_avl_write_req) begin
                n_wr++;
                vectors++;
                if ({ddr3_avl_addr, ddr3_avl_wr_data, ddr3_avl_size, ddr3_avl_burstbegin, ddr3_avl_read_req}
                    !== {26'h0000100, exp_data, 3'd1, 1'b1, 1'b0}) begin
                    miscompares++;
                    $display("FAIL wr_cmd: addr=%h data=%h size=%0d bb=%b rd=%b, expected addr=100 data=%h size=1 bb=1 rd=0",
                             ddr3_avl_addr, ddr3_avl_wr_data, ddr3_avl_size, ddr3_avl_burstbegin,
                             ddr3_avl_read_req, exp_data);
                end
            end
            if (wr_done) begin
                n_done++;
                wr_req = 1'b0;
                vectors++;
                if ({ddr3_avl_addr, ddr3_avl_wr_data, ddr3_avl_write_req} !== {26'h0000100, exp_data, 1'b0}) begin
                    miscompares++;
                    $display("FAIL wr_done_hold: addr=%h data=%h wreq=%b, expected addr=100 data=%h wreq=0",
                             ddr3_avl_addr, ddr3_avl_wr_data, ddr3_avl_write_req, exp_data);
                end
            end
            // Controller holds ready low for the first three command cycles.
            ddr3_avl_ready = (n_wr == 4);
        end
        ddr3_avl_ready = 1'b0;
        vectors++;
        if (n_wr !== 4) begin
            miscompares++;
            $display("FAIL wr_req_cycles: got %0d, expected 4", n_wr);
        end
        vectors++;
        if (n_done !== 1) begin
            miscompares++;
            $display("FAIL wr_done_count: got %0d, expected 1", n_done);
        end
    endtask

    // Runs a read with a per-edge rdata_valid pattern; stops early after stop_beats beats.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input int first, input logic [11:0] pat,
                           input int stop_beats, output int n_beats, output int n_done,
                           output bit done_on_last);
        int sent;
        bit seen;
        n_beats = 0; n_done = 0; done_on_last = 1'b0; sent = 0; seen = 1'b0;
        rd_addr = addr;
        rd_req  = 1'b1;
        ddr3_avl_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = ddr3_avl_read_req;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rd_cmd_wait: read_req=%b after 10 cycles, expected 1", ddr3_avl_read_req);
            rd_req = 1'b0;
            return;
        end
        vectors++;
        if ({ddr3_avl_addr, ddr3_avl_size, ddr3_avl_burstbegin} !== {addr, 3'(RD_BURST), 1'b1}) begin
            miscompares++;
            $display("FAIL rd_cmd: addr=%h size=%0d bb=%b, expected addr=%h size=%0d bb=1",
                     ddr3_avl_addr, ddr3_avl_size, ddr3_avl_burstbegin, addr, RD_BURST);
        end
        // Stray beat during the command phase must not be forwarded.
        ddr3_avl_rdata_valid = 1'b1;
        ddr3_avl_rdata = 128'hBAD;
        step();
        vectors++;
        if ({ddr3_avl_read_req, rd_data_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_cmd_exit: read_req=%b rd_valid=%b, expected 0 0", ddr3_avl_read_req, rd_data_valid);
        end
        for (int i = 0; i < 16 && n_beats < stop_beats; i++) begin
            if (i < 12 && pat[i]) begin
                ddr3_avl_rdata_valid = 1'b1;
                ddr3_avl_rdata = DATA_W'(first + sent);
                sent++;
            end else begin
                ddr3_avl_rdata_valid = 1'b0;
            end
            step();
            if (rd_data_valid) begin
                n_beats++;
                vectors++;
                if (rd_data !== DATA_W'(first + n_beats - 1)) begin
                    miscompares++;
                    $display("FAIL rd_beat%0d: got %h, expected %h", n_beats, rd_data, DATA_W'(first + n_beats - 1));
                end
            end
            if (rd_done) begin
                n_done++;
                done_on_last = rd_data_valid && (n_beats == RD_BURST);
                rd_req = 1'b0;
            end
        end
        ddr3_avl_rdata_valid = 1'b0;
    endtask

    task automatic test_read();
        int nb, nd;
        bit dl;
        do_read(26'h0000200, 1, 12'h065, 99, nb, nd, dl);
        vectors++;
        if ({nb, nd, dl} !== {32'd4, 32'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL rd_burst: beats=%0d done=%0d done_on_last=%b, expected 4 1 1", nb, nd, dl);
        end
        vectors++;
        if (rd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_err_clean: got %b, expected 0", rd_err);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int order[4];
        bit prev_done;
        n = 0;
        prev_done = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        wr_addr = 26'h0000400; wr_data = 128'h55;
        rd_addr = 26'h0000500;
        ddr3_avl_ready = 1'b1;
        ddr3_avl_rdata = '0;
        ddr3_avl_rdata_valid = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int c = 0; c < 80 && n < 4; c++) begin
            step();
            if (prev_done) begin
                vectors++;
                if ({ddr3_avl_write_req, ddr3_avl_read_req} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rr_done_gap: strobes wr=%b rd=%b, expected 0 0",
                             ddr3_avl_write_req, ddr3_avl_read_req);
                end
            end
            if (ddr3_avl_write_req) begin
                order[n] = 0;
                n++;
            end else if (ddr3_avl_read_req) begin
                order[n] = 1;
                n++;
            end
            prev_done = wr_done | rd_done;
        end
        wr_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (rd_done) rd_req = 1'b0;
        end
        rd_req = 1'b0;
        ddr3_avl_rdata_valid = 1'b0;
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL rr_grants: got %0d grants, expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (order[i] !== (i % 2)) begin
                miscompares++;
                $display("FAIL rr_order%0d: got %0d, expected %0d (0=write 1=read)", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int nb, nd;
        bit dl;
        do_read(26'h0000200, 32'h21, 12'hFFF, 2, nb, nd, dl);
        vectors++;
        if ({nb, nd} !== {32'd2, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_pre: beats=%0d done=%0d, expected 2 0", nb, nd);
        end
        ddr3_avl_rdata_valid = 1'b1;
        ddr3_avl_rdata = 128'h77;
        rd_req = 1'b0;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (w_ctl !== 10'd0) begin
            miscompares++;
            $display("FAIL mid_reset_ctl: got %b, expected %b", w_ctl, 10'd0);
        end
        vectors++;
        if ({ddr3_avl_addr, rd_data} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_data: addr=%h rdata=%h, expected 0 0", ddr3_avl_addr, rd_data);
        end
        repeat (2) step();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if ({rd_data_valid, rd_done, ddr3_avl_read_req} !== 3'b000) begin
                miscompares++;
                $display("FAIL mid_ignored%0d: valid=%b done=%b rreq=%b, expected 0 0 0",
                         c, rd_data_valid, rd_done, ddr3_avl_read_req);
            end
        end
        ddr3_avl_rdata_valid = 1'b0;
        do_read(26'h0000300, 16, 12'hFFF, 99, nb, nd, dl);
        vectors++;
        if ({nb, nd, dl} !== {32'd4, 32'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_recover: beats=%0d done=%0d done_on_last=%b, expected 4 1 1", nb, nd, dl);
        end
    endtask

`ifdef DDR3_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        bit seen;
        seen = 1'b0;
        rd_addr = 26'h0000600;
        rd_req = 1'b1;
        ddr3_avl_ready = 1'b1;
        ddr3_avl_rdata_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = ddr3_avl_read_req;
        end
        step();
        k = 1;
        while (!rd_done && k < 40) begin
            step();
            k++;
        end
        rd_req = 1'b0;
        // Done appears right after the 16th silent READ_DATA cycle.
        vectors++;
        if (k !== TIMEOUT_CYCLES + 1) begin
            miscompares++;
            $display("FAIL wdog_cycle: done at sample %0d, expected %0d", k, TIMEOUT_CYCLES + 1);
        end
        vectors++;
        if ({rd_err, rd_data_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL wdog_flags: err=%b valid=%b, expected 1 0", rd_err, rd_data_valid);
        end
        repeat (5) step();
        vectors++;
        if (rd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL wdog_sticky: got %b, expected 1", rd_err);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (rd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wdog_reset: got %b, expected 0", rd_err);
        end
        step();
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid_burst();
`ifdef DDR3_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded 100000 ns, expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
